arcade_ctrl_mux: RTL and testbench

//  Parametrised control front-end between hps_io and an arcade game core.

---
 rtl/arcade_ctrl_pkg.sv | 31 +++
 rtl/ctrl_oneshot.sv | 68 ++++++
 rtl/arcade_ctrl_mux.sv | 144 ++++++++++++++
 tb/tb_arcade_ctrl_mux.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_ctrl_pkg.sv
// Shared definitions for the arcade control front-end: joystick bit map, ctrl_n bit order, coin FSM states.
package arcade_ctrl_pkg;
  localparam int JOY_W  = 16;
  localparam int CTRL_W = 9;

  localparam int JOY_R      = 0;
  localparam int JOY_L      = 1;
  localparam int JOY_D      = 2;
  localparam int JOY_U      = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_FAST   = 5;
  localparam int JOY_START1 = 6;
  localparam int JOY_START2 = 7;
  localparam int JOY_COIN   = 8;
  localparam int JOY_PAUSE  = 9;

  localparam int C_RIGHT  = 0;
  localparam int C_LEFT   = 1;
  localparam int C_DOWN   = 2;
  localparam int C_UP     = 3;
  localparam int C_FIRE1  = 4;
  localparam int C_FIRE2  = 5;
  localparam int C_START1 = 6;
  localparam int C_START2 = 7;
  localparam int C_COIN   = 8;

  // Coin and pause history reset as "held" so a button held through reset is not seen as a new press.
  localparam logic [JOY_W-1:0] JOY_RST = 16'h0300;

  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_LOCK} coin_st_t;
endpackage

// File: rtl/ctrl_oneshot.sv
// Coin one-shot: rising edge -> COIN_CYCLES-cycle active-low pulse, then an equal lockout.
// Pulse starts one cycle after the edge is seen; edges arriving during PULSE or LOCK are dropped.
module ctrl_oneshot
  import arcade_ctrl_pkg::*;
#(
  parameter int COIN_CYCLES = 2_000_000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic btn,
  output logic pulse_n
);
  localparam int CW = $clog2(COIN_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(COIN_CYCLES - 1);

  coin_st_t      st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q, prev_d;
  logic          pulse_n_q, pulse_n_d;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    prev_d = btn;
    case (st_q)
      C_IDLE: begin
        if (btn && !prev_q) begin
          st_d  = C_PULSE;
          cnt_d = RELOAD;
        end
      end
      C_PULSE: begin
        if (cnt_q == '0) begin
          st_d  = C_LOCK;
          cnt_d = RELOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      C_LOCK: begin
        if (cnt_q == '0) st_d = C_IDLE;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: begin
        st_d  = C_IDLE;
        cnt_d = '0;
      end
    endcase
    pulse_n_d = (st_d != C_PULSE);
  end

  // prev resets high: a button held through reset must be released before it can fire
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      st_q      <= C_IDLE;
      cnt_q     <= '0;
      prev_q    <= 1'b1;
      pulse_n_q <= 1'b1;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      pulse_n_q <= pulse_n_d;
    end
  end

  assign pulse_n = pulse_n_q;
endmodule

// File: rtl/arcade_ctrl_mux.sv
// Arcade control front-end: DIP capture from ioctl, joysticks -> active-low vectors (1 cycle), coin pulses, pause toggle.
// Autofire on fast fire is built only when ARCADE_CTRL_AUTOFIRE_EN is defined; no backpressure anywhere.
module arcade_ctrl_mux
  import arcade_ctrl_pkg::*;
#(
  parameter int                   NUM_PLAYERS = 2,
  parameter int                   NUM_DIP     = 8,
  parameter logic [7:0]           DIP_INDEX   = 8'd254,
  parameter logic [NUM_DIP*8-1:0] DIP_DEFAULT = '1,
  parameter int                   COIN_CYCLES = 2_000_000,
  parameter int                   AF_HALF     = 666_666
) (
  input  logic                            clk_sys,
  input  logic                            reset,
  input  logic                            ioctl_wr,
  input  logic [7:0]                      ioctl_index,
  input  logic [24:0]                     ioctl_addr,
  input  logic [7:0]                      ioctl_dout,
  input  logic [NUM_PLAYERS*JOY_W-1:0]    joystick,
  output logic [NUM_PLAYERS*CTRL_W-1:0]   ctrl_n,
  output logic [NUM_DIP*8-1:0]            dip,
  output logic                            pause_req
);
  localparam int JW = NUM_PLAYERS * JOY_W;

  logic [JW-1:0]          joy_q, joy_d;
  logic [NUM_PLAYERS-1:0] fire_v, ff_v, coin_v, pause_v;
  logic [NUM_PLAYERS-1:0] coin_n, fire1_on, fire2_on;
  logic [NUM_PLAYERS-1:0] pause_prev_q, pause_prev_d;
  logic                   pause_req_q, pause_req_d;
  logic [NUM_DIP*8-1:0]   dip_q = DIP_DEFAULT;
  logic [NUM_DIP*8-1:0]   dip_d;
  logic                   unused_joy;

  always_comb begin
    dip_d = dip_q;
    if (ioctl_wr && ioctl_index == DIP_INDEX) begin
      for (int k = 0; k < NUM_DIP; k++) begin
        if (ioctl_addr == 25'(k)) dip_d[k*8 +: 8] = ioctl_dout;
      end
    end
  end

  // DIP switches survive core resets; only power-up sets them to the default.
  always_ff @(posedge clk_sys) begin
    dip_q <= dip_d;
  end

  always_comb begin
    joy_d   = joystick;
    fire_v  = '0;
    ff_v    = '0;
    coin_v  = '0;
    pause_v = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      fire_v[p]  = joy_q[p*JOY_W + JOY_FIRE];
      ff_v[p]    = joy_q[p*JOY_W + JOY_FAST];
      coin_v[p]  = joy_q[p*JOY_W + JOY_COIN];
      pause_v[p] = joy_q[p*JOY_W + JOY_PAUSE];
    end
    pause_prev_d = pause_v;
    pause_req_d  = pause_req_q ^ (|(pause_v & ~pause_prev_q));
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
    ctrl_oneshot #(.COIN_CYCLES(COIN_CYCLES)) u_coin (
      .clk_sys (clk_sys),
      .reset   (reset),
      .btn     (coin_v[p]),
      .pulse_n (coin_n[p])
    );
  end

`ifdef ARCADE_CTRL_AUTOFIRE_EN
  localparam int AW = $clog2(AF_HALF + 1);
  localparam logic [AW-1:0] AF_LAST = AW'(AF_HALF - 1);

  logic [AW-1:0]          af_cnt_q, af_cnt_d, af_base;
  logic [NUM_PLAYERS-1:0] ff_prev_q, ff_rise, af_ph_q, af_ph_d, af_ph_now;
  logic                   af_wrap;

  // Any fast-fire press restarts the shared counter so the presser's first low half is full length.
  always_comb begin
    ff_rise   = ff_v & ~ff_prev_q;
    af_ph_now = af_ph_q & ~ff_rise;
    af_base   = (|ff_rise) ? '0 : af_cnt_q;
    af_wrap   = (af_base == AF_LAST);
    af_cnt_d  = af_wrap ? '0 : af_base + 1'b1;
    af_ph_d   = af_ph_now ^ {NUM_PLAYERS{af_wrap}};
    fire1_on  = fire_v | (ff_v & ~af_ph_now);
    fire2_on  = '0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      af_cnt_q  <= '0;
      ff_prev_q <= '0;
      af_ph_q   <= '0;
    end else begin
      af_cnt_q  <= af_cnt_d;
      ff_prev_q <= ff_v;
      af_ph_q   <= af_ph_d;
    end
  end
`else
  localparam int af_half_unused = AF_HALF;

  always_comb begin
    fire1_on = fire_v;
    fire2_on = ff_v;
  end
`endif

  always_comb begin
    ctrl_n = '1;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      ctrl_n[p*CTRL_W + C_RIGHT]  = ~joy_q[p*JOY_W + JOY_R];
      ctrl_n[p*CTRL_W + C_LEFT]   = ~joy_q[p*JOY_W + JOY_L];
      ctrl_n[p*CTRL_W + C_DOWN]   = ~joy_q[p*JOY_W + JOY_D];
      ctrl_n[p*CTRL_W + C_UP]     = ~joy_q[p*JOY_W + JOY_U];
      ctrl_n[p*CTRL_W + C_FIRE1]  = ~fire1_on[p];
      ctrl_n[p*CTRL_W + C_FIRE2]  = ~fire2_on[p];
      ctrl_n[p*CTRL_W + C_START1] = ~joy_q[p*JOY_W + JOY_START1];
      ctrl_n[p*CTRL_W + C_START2] = ~joy_q[p*JOY_W + JOY_START2];
      ctrl_n[p*CTRL_W + C_COIN]   = coin_n[p];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      joy_q        <= {NUM_PLAYERS{JOY_RST}};
      pause_prev_q <= '1;
      pause_req_q  <= 1'b0;
    end else begin
      joy_q        <= joy_d;
      pause_prev_q <= pause_prev_d;
      pause_req_q  <= pause_req_d;
    end
  end

  assign unused_joy = ^joy_q;
  assign dip        = dip_q;
  assign pause_req  = pause_req_q;
endmodule

// File: tb/tb_arcade_ctrl_mux.sv
// Randomised + directed bench for arcade_ctrl_mux with a cycle-level behavioural model.
module tb_arcade_ctrl_mux;
  localparam int NP = 2;
  localparam int ND = 8;
  localparam int CC = 8;
  localparam int AF = 4;

  logic            clk_sys     = 1'b0;
  logic            reset       = 1'b1;
  logic            ioctl_wr    = 1'b0;
  logic [7:0]      ioctl_index = '0;
  logic [24:0]     ioctl_addr  = '0;
  logic [7:0]      ioctl_dout  = '0;
  logic [NP*16-1:0] joystick   = '0;
  logic [NP*9-1:0] ctrl_n;
  logic [ND*8-1:0] dip;
  logic            pause_req;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  always #5 clk_sys = ~clk_sys;

  arcade_ctrl_mux #(
    .NUM_PLAYERS(NP), .NUM_DIP(ND), .DIP_INDEX(8'd254), .DIP_DEFAULT('1),
    .COIN_CYCLES(CC), .AF_HALF(AF)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .joystick(joystick),
    .ctrl_n(ctrl_n), .dip(dip), .pause_req(pause_req)
  );

  // ---------------- behavioural model ----------------
  // jh1 = joystick value captured at the latest edge, jh2 = the one before.
  logic [15:0]     jh1 [NP];
  logic [15:0]     jh2 [NP];
  int              last_start [NP];
  int              tc = 0;
  int              r0 = 0;
  bit              m_pause = 1'b0;
  logic [ND*8-1:0] m_dip = '1;
  logic [NP*9-1:0] exp_ctrl = '1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int p = 0; p < NP; p++) begin
      jh1[p] = 16'h0300;
      jh2[p] = 16'h0300;
      last_start[p] = -1000;
    end
    m_pause = 1'b0;
  endtask

  function automatic void m_build();
    logic [NP*9-1:0] e;
    logic [15:0] j;
    bit pressed;
    e = '1;
    for (int p = 0; p < NP; p++) begin
      j = jh1[p];
      e[p*9+0] = ~j[0];
      e[p*9+1] = ~j[1];
      e[p*9+2] = ~j[2];
      e[p*9+3] = ~j[3];
`ifdef ARCADE_CTRL_AUTOFIRE_EN
      pressed = j[4] || (p == 0 && j[5] && (((tc - r0) / AF) % 2 == 0));
      e[p*9+4] = ~pressed;
      e[p*9+5] = 1'b1;
`else
      pressed = j[4];
      e[p*9+4] = ~pressed;
      e[p*9+5] = ~j[5];
`endif
      e[p*9+6] = ~j[6];
      e[p*9+7] = ~j[7];
      e[p*9+8] = !((tc - last_start[p]) < CC);
    end
    exp_ctrl = e;
  endfunction

  always @(posedge clk_sys or posedge reset) begin
    bit any_p;
    if (reset) begin
      m_reset();
    end else begin
      tc++;
      any_p = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (jh1[p][8] && !jh2[p][8] && (tc - last_start[p] > 2*CC)) last_start[p] = tc;
        if (jh1[p][9] && !jh2[p][9]) any_p = 1'b1;
      end
      if (any_p) m_pause = !m_pause;
`ifdef ARCADE_CTRL_AUTOFIRE_EN
      if (joystick[5] && !jh1[0][5]) r0 = tc;
`endif
      for (int p = 0; p < NP; p++) begin
        jh2[p] = jh1[p];
        jh1[p] = joystick[p*16 +: 16];
      end
    end
    m_build();
  end

  always @(posedge clk_sys) begin
    if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd8)
      m_dip[int'(ioctl_addr)*8 +: 8] = ioctl_dout;
  end

  always @(negedge clk_sys) begin
    if (started) begin
      chk("ctrl_n_model", 64'(ctrl_n), 64'(exp_ctrl));
      chk("pause_model", 64'(pause_req), 64'(m_pause));
      chk("dip_model", dip, m_dip);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic count_coin(input int n, input int p1, input int p2, input int p3, input int hold,
                            output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      step();
      joystick[8] = (i < hold) || (i == p1) || (i == p2) || (i == p3);
      @(negedge clk_sys);
      if (ctrl_n[8] === 1'b0) lows++;
    end
  endtask

  initial begin
    int lows;
    logic [19:0] f1, f2;
    repeat (3) step();
    started = 1'b1;
    reset = 1'b0;
    @(negedge clk_sys);
    chk("reset_ctrl_n", 64'(ctrl_n), 64'h3FFFF);
    chk("reset_pause", 64'(pause_req), 64'h0);
    chk("powerup_dip", dip, 64'hFFFF_FFFF_FFFF_FFFF);

    // DIP capture, out-of-range address and foreign index ignored
    for (int k = 0; k < 10; k++) begin
      step();
      ioctl_wr    = 1'b1;
      ioctl_index = (k == 9) ? 8'd253 : 8'd254;
      ioctl_addr  = (k == 9) ? 25'd0 : 25'(k);
      ioctl_dout  = (k < 8) ? 8'(8'hA0 + k) : ((k == 8) ? 8'hFF : 8'h00);
    end
    step();
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("dip_capture", dip, 64'hA7A6_A5A4_A3A2_A1A0);
    step(); reset = 1'b1;
    step(); step(); reset = 1'b0;
    @(negedge clk_sys);
    chk("dip_after_reset", dip, 64'hA7A6_A5A4_A3A2_A1A0);

    // right + fire on player 0
    step();
    joystick = 32'h0000_0011;
    @(posedge clk_sys); @(negedge clk_sys);
    chk("p0_right_fire", 64'(ctrl_n[8:0]), 64'h1EE);
    chk("p1_untouched", 64'(ctrl_n[17:9]), 64'h1FF);
    step(); joystick = '0;
    repeat (3) step();

    // coin shaping
    count_coin(40, -1, -1, -1, 30, lows);
    chk("coin_held_len", 64'(lows), 64'd8);
    count_coin(50, 7, 11, 15, 2, lows);
    chk("coin_drop_in_pulse_lock", 64'(lows), 64'd8);
    count_coin(30, -1, -1, -1, 2, lows);
    chk("coin_after_lock", 64'(lows), 64'd8);

    // pause toggle
    step();
    joystick = (32'd1 << 9) | (32'd1 << 25);
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("pause_dual_edge", 64'(pause_req), 64'h1);
    step(); joystick = '0;
    repeat (3) step();
    joystick = 32'd1 << 9;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("pause_second", 64'(pause_req), 64'h0);

    // fast fire held 20 cycles
    step();
    joystick = 32'd1 << 5;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_sys); @(negedge clk_sys);
      f1[i] = ctrl_n[4];
      f2[i] = ctrl_n[5];
    end
`ifdef ARCADE_CTRL_AUTOFIRE_EN
    chk("autofire_fire1", 64'(f1), 64'h0F0F0);
    chk("autofire_fire2", 64'(f2), 64'hFFFFF);
`else
    chk("fastfire_fire1", 64'(f1), 64'hFFFFF);
    chk("fastfire_fire2", 64'(f2), 64'h00000);
`endif
    step(); joystick = '0;
    repeat (20) step();

    // reset mid-pulse, held coin must not retrigger
    joystick = 32'd1 << 8;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("coin_in_pulse", 64'(ctrl_n[8]), 64'h0);
    step();
    reset = 1'b1;
    #1;
    chk("reset_async_coin", 64'(ctrl_n), 64'h3FFFF);
    step(); step(); reset = 1'b0;
    count_coin(20, -1, -1, -1, 20, lows);
    chk("held_through_reset", 64'(lows), 64'd0);
    step(); joystick = '0;
    repeat (3) step();
    count_coin(20, -1, -1, -1, 2, lows);
    chk("repress_after_reset", 64'(lows), 64'd8);

    // randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      step();
      joystick = NP*16'($urandom);
`ifdef ARCADE_CTRL_AUTOFIRE_EN
      joystick[21] = 1'b0;
`endif
      ioctl_wr    = $urandom_range(0, 1) == 1;
      ioctl_index = ($urandom_range(0, 3) == 0) ? 8'd253 : 8'd254;
      ioctl_addr  = 25'($urandom_range(0, 11));
      ioctl_dout  = 8'($urandom);
      reset       = ($urandom_range(0, 99) == 0);
    end
    step();
    reset = 1'b0;
    ioctl_wr = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
